// File: rtl/cam_match_enc_pkg.sv
// Shared fractcam definitions: default CAM geometry, a clog2 helper and the
// legal-parameter check used by every block that is sized by DEPTH/CHUNK.
`ifndef CAM_MATCH_ENC_PKG_SV
`define CAM_MATCH_ENC_PKG_SV

// Expands to a generate-time guard; place it directly in a module body.
`define CAM_CHECK_PARAMS(depth, chunk) \
  if (!(((depth) >= 8) && (((depth) & ((depth) - 1)) == 0) && ((chunk) >= 1) && \
        (((chunk) & ((chunk) - 1)) == 0) && ((chunk) <= (depth)))) begin : g_bad_params \
    $error("fractcam: illegal geometry DEPTH=%0d CHUNK=%0d", depth, chunk); \
  end

package cam_match_enc_pkg;

  localparam int FRACTCAM_DEPTH = 64;
  localparam int DEFAULT_CHUNK  = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/cam_prio_chunk.sv
// Combinational lowest-set-bit encoder: reports any-hit, the lowest set
// position and whether two or more bits are set.
module cam_prio_chunk
  import cam_match_enc_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IW    = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             hit,
  output logic [IW-1:0]    idx,
  output logic             multi
);

  always_comb begin
    // NOTE: every output is assigned before the search loop, so no path leaves one holding its old value (no latch).
    hit   = |vec;
    multi = |(vec & (vec - WIDTH'(1)));
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/cam_match_enc.sv
// Two-stage pipelined priority encoder behind the fractcam AND stage: stage 1
// encodes each CHUNK-wide group, stage 2 picks the lowest hitting group.
module cam_match_enc
  import cam_match_enc_pkg::*;
#(
  parameter  int DEPTH     = FRACTCAM_DEPTH,
  parameter  int CHUNK     = DEFAULT_CHUNK,
  parameter  int TAG_WIDTH = 8,
  localparam int IDX_WIDTH = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DEPTH-1:0]     s_match,
  input  logic [TAG_WIDTH-1:0] s_tag,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [IDX_WIDTH-1:0] m_index,
  output logic                 m_hit,
  output logic                 m_multi,
  output logic [TAG_WIDTH-1:0] m_tag,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int NGRP = DEPTH / CHUNK;
  localparam int CB   = clog2(CHUNK);
  localparam int CIW  = (CHUNK > 1) ? CB : 1;
  localparam int GIW  = (NGRP > 1) ? clog2(NGRP) : 1;

  `CAM_CHECK_PARAMS(DEPTH, CHUNK)

  logic                 s1_valid_q, s1_valid_d;
  logic [NGRP-1:0]      grp_hit_q, grp_hit_d;
  logic [NGRP-1:0]      grp_multi_q, grp_multi_d;
  logic [CIW-1:0]       grp_idx_q [NGRP];
  logic [CIW-1:0]       grp_idx_d [NGRP];
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

  logic                 m_valid_q, m_valid_d;
  logic                 m_hit_q, m_hit_d;
  logic                 m_multi_q, m_multi_d;
  logic [IDX_WIDTH-1:0] m_index_q, m_index_d;
  logic [TAG_WIDTH-1:0] m_tag_q, m_tag_d;

  logic                 stage1_en, stage2_en, s1_load, s2_load;
  logic [NGRP-1:0]      c_hit, c_multi;
  logic [CIW-1:0]       c_idx [NGRP];
  logic                 any_hit, grp_many, sel_multi;
  logic [GIW-1:0]       gsel;
  logic [CIW-1:0]       sel_idx;

  for (genvar g = 0; g < NGRP; g++) begin : g_chunk
    cam_prio_chunk #(.WIDTH(CHUNK)) u_chunk (
      .vec   (s_match[g*CHUNK +: CHUNK]),
      .hit   (c_hit[g]),
      .idx   (c_idx[g]),
      .multi (c_multi[g])
    );
  end

  cam_prio_chunk #(.WIDTH(NGRP)) u_grp_sel (
    .vec   (grp_hit_q),
    .hit   (any_hit),
    .idx   (gsel),
    .multi (grp_many)
  );

  // With a single group there is no group field; avoid a 1-bit select into a 1-entry array.
  if (NGRP == 1) begin : g_one_grp
    assign sel_idx   = grp_idx_q[0];
    assign sel_multi = grp_multi_q[0];
  end else begin : g_many_grp
    assign sel_idx   = grp_idx_q[gsel];
    assign sel_multi = grp_multi_q[gsel];
  end

  always_comb begin
    stage2_en = !m_valid_q || m_ready;
    stage1_en = !s1_valid_q || stage2_en;
    s1_load   = stage1_en && s_valid;
    s2_load   = stage2_en && s1_valid_q;

    s1_valid_d  = stage1_en ? s_valid : s1_valid_q;
    grp_hit_d   = s1_load ? c_hit : grp_hit_q;
    grp_multi_d = s1_load ? c_multi : grp_multi_q;
    s1_tag_d    = s1_load ? s_tag : s1_tag_q;
    for (int g = 0; g < NGRP; g++) begin
      grp_idx_d[g] = s1_load ? c_idx[g] : grp_idx_q[g];
    end

    // An empty match vector selects group 0 whose chunk index is 0, so no-hit yields index 0.
    m_valid_d = stage2_en ? s1_valid_q : m_valid_q;
    m_hit_d   = s2_load ? any_hit : m_hit_q;
    m_multi_d = s2_load ? (sel_multi || grp_many) : m_multi_q;
    m_index_d = s2_load ? ((IDX_WIDTH'(gsel) << CB) | IDX_WIDTH'(sel_idx)) : m_index_q;
    m_tag_d   = s2_load ? s1_tag_q : m_tag_q;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_hit_q    <= 1'b0;
      m_multi_q  <= 1'b0;
      m_index_q  <= '0;
      m_tag_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      m_valid_q  <= m_valid_d;
      m_hit_q    <= m_hit_d;
      m_multi_q  <= m_multi_d;
      m_index_q  <= m_index_d;
      m_tag_q    <= m_tag_d;
    end
  end

  // NOTE: stage-1 payload is only ever consumed under s1_valid_q, so it is deliberately left off the reset.
  always_ff @(posedge clk) begin
    grp_hit_q   <= grp_hit_d;
    grp_multi_q <= grp_multi_d;
    grp_idx_q   <= grp_idx_d;
    s1_tag_q    <= s1_tag_d;
  end

  assign s_ready = stage1_en;
  assign m_valid = m_valid_q;
  assign m_hit   = m_hit_q;
  assign m_multi = m_multi_q;
  assign m_index = m_index_q;
  assign m_tag   = m_tag_q;

endmodule
